wav_mcu_irq_ctrl: RTL

//  Interrupt aggregator feeding the MCU core: collects NUM_IRQ async sources, synchronizes them and

---
 rtl/wav_mcu_pkg.sv | 17 +
 rtl/wav_mcu_irq_sync.sv | 32 +++
 rtl/wav_mcu_irq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wav_mcu_pkg.sv
// Shared MCU subsystem definitions.
// Holds the interrupt source count, the interrupt controller register map
// (byte offsets within the MCUINTF space) and the source vector type.
package wav_mcu_pkg;

    localparam int unsigned WAV_NUM_IRQ = 24;

    // Interrupt controller register offsets
    localparam logic [4:0] WAV_MCU_IRQ_EN   = 5'h00;
    localparam logic [4:0] WAV_MCU_IRQ_MODE = 5'h04;
    localparam logic [4:0] WAV_MCU_IRQ_PEND = 5'h08;
    localparam logic [4:0] WAV_MCU_IRQ_ID   = 5'h0C;
    localparam logic [4:0] WAV_MCU_IRQ_RAW  = 5'h10;

    typedef logic [WAV_NUM_IRQ-1:0] irq_vec_t;

endpackage

// File: rtl/wav_mcu_irq_sync.sv
// Multi-flop synchronizer for a vector of asynchronous interrupt sources.
// Ports:
//   i_clk    core clock
//   i_rst_n  asynchronous active-low reset, clears every stage
//   i_d      raw asynchronous inputs
//   o_q      inputs after SYNC_STAGES flops
module wav_mcu_irq_sync #(
    parameter int unsigned NUM_IRQ     = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_d,
    output logic [NUM_IRQ-1:0] o_q
);

    localparam int unsigned CHAIN_W = SYNC_STAGES * NUM_IRQ;

    // Stage k occupies bits [(k+1)*NUM_IRQ-1 : k*NUM_IRQ]; stage 0 is nearest the input
    logic [CHAIN_W-1:0] chain_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[CHAIN_W-NUM_IRQ-1:0], i_d};
        end
    end

    assign o_q = chain_q[CHAIN_W-1 -: NUM_IRQ];

endmodule

// File: rtl/wav_mcu_irq_ctrl.sv
// MCU interrupt aggregator.
// Synchronizes NUM_IRQ async sources, latches pending state (edge or level
// per source), masks with per-source enable and presents one registered
// level interrupt plus the lowest-index winning source ID. Firmware access is
// through a single-cycle register port.
// Ports:
//   i_clk, i_rst_n     core clock, asynchronous active-low reset
//   i_irq              raw async interrupt sources, active high
//   i_req/i_we/i_addr/i_wdata  register access request (one cycle)
//   o_ack/o_rdata      access done one cycle after i_req, read data (0 otherwise)
//   o_irq/o_irq_id     registered interrupt level and winning source index
module wav_mcu_irq_ctrl
    import wav_mcu_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = WAV_NUM_IRQ,
    parameter int unsigned ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [4:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic               o_ack,
    output logic [31:0]        o_rdata,
    output logic               o_irq,
    output logic [ID_W-1:0]    o_irq_id
);

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] s_d_q;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] act;
    logic               ack_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [4:0]         addr_w;
    logic [31:0]        rd_mux;
    logic [31:0]        id_word;
    logic               wr;
    logic               unused_ok;

    wav_mcu_irq_sync #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_irq),
        .o_q     (s)
    );

    // Byte-address low bits and write bits above NUM_IRQ carry no meaning
    assign unused_ok = ^{i_addr[1:0], i_wdata};

    assign addr_w = {i_addr[4:2], 2'b00};
    assign wr     = i_req & i_we;
    assign rise   = s & ~s_d_q;

    // Register writes and W1C strobe
    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        w1c    = '0;
        if (wr) begin
            case (addr_w)
                WAV_MCU_IRQ_EN:   en_d   = i_wdata[NUM_IRQ-1:0];
                WAV_MCU_IRQ_MODE: mode_d = i_wdata[NUM_IRQ-1:0];
                WAV_MCU_IRQ_PEND: w1c    = i_wdata[NUM_IRQ-1:0];
                default: ;
            endcase
        end
    end

    // Level sources mirror s; edge sources latch rises, and a rise beats a same-cycle W1C
    assign pend_d = (~mode_q & s) | (mode_q & (rise | (pend_q & ~w1c)));

    // Lowest-index enabled pending source wins
    assign act = pend_q & en_q;
    always_comb begin
        irq_d = 1'b0;
        id_d  = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (act[i] && !irq_d) begin
                irq_d = 1'b1;
                id_d  = ID_W'(i);
            end
        end
    end

    // Read mux samples state before any same-cycle write
    always_comb begin
        id_word           = '0;
        id_word[31]       = irq_q;
        id_word[ID_W-1:0] = id_q;
    end

    always_comb begin
        rd_mux = '0;
        case (addr_w)
            WAV_MCU_IRQ_EN:   rd_mux = 32'(en_q);
            WAV_MCU_IRQ_MODE: rd_mux = 32'(mode_q);
            WAV_MCU_IRQ_PEND: rd_mux = 32'(pend_q);
            WAV_MCU_IRQ_ID:   rd_mux = id_word;
            WAV_MCU_IRQ_RAW:  rd_mux = 32'(s);
            default:          rd_mux = '0;
        endcase
    end

    assign rdata_d = (i_req && !i_we) ? rd_mux : 32'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_d_q   <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            s_d_q   <= s;
            en_q    <= en_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            ack_q   <= i_req;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
        end
    end

    assign o_ack    = ack_q;
    assign o_rdata  = rdata_q;
    assign o_irq    = irq_q;
    assign o_irq_id = id_q;

endmodule
